// File: rtl/pep_ks_mult_ctrl_pkg.sv
// Shared sizing and types for the key-switch multiplier sequencer.
package pep_ks_mult_ctrl_pkg;
    localparam int KS_B_W           = 4;
    localparam int LBY              = 3;
    localparam int LBZ              = 2;
    localparam int KS_LG_NB         = 4;
    localparam int TOTAL_BATCH_NB_W = 2;
    localparam int PID_W            = 4;

    localparam int LVL_CYC     = (KS_LG_NB + LBZ - 1) / LBZ;
    localparam int ROW_DATA_W  = LBZ * KS_B_W;
    localparam int LINE_DATA_W = LBY * ROW_DATA_W;
    localparam int LINE_SIGN_W = LBY * LBZ;

    typedef struct packed {
        logic                        eol;
        logic                        eoy;
        logic                        last_iter;
        logic [TOTAL_BATCH_NB_W-1:0] batch_id;
        logic [PID_W-1:0]            pid;
    } ks_ctrl_info_t;

    typedef struct packed {
        logic [LINE_DATA_W-1:0] data;
        logic [LINE_SIGN_W-1:0] sign;
        ks_ctrl_info_t          info;
    } ks_line_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } ks_state_e;
endpackage

// File: rtl/pep_ks_mult_ctrl_if.sv
// Decomposed BLWE coefficient line stream into the multiplier sequencer.
interface pep_ks_mult_ctrl_if;
    import pep_ks_mult_ctrl_pkg::*;

    logic [LINE_DATA_W-1:0]      in_data;
    logic [LINE_SIGN_W-1:0]      in_sign;
    logic                        in_eol;
    logic                        in_eoy;
    logic                        in_last_iter;
    logic [TOTAL_BATCH_NB_W-1:0] in_batch_id;
    logic [PID_W-1:0]            in_pid;
    logic                        in_vld;
    logic                        in_rdy;

    modport master (
        output in_data, in_sign, in_eol, in_eoy, in_last_iter, in_batch_id, in_pid, in_vld,
        input  in_rdy
    );

    modport slave (
        input  in_data, in_sign, in_eol, in_eoy, in_last_iter, in_batch_id, in_pid, in_vld,
        output in_rdy
    );
endinterface

// File: rtl/pep_ks_mult_ctrl_skew.sv
// ROW-stage delay line; only the valid flag is reset so data can map to plain flops.
module pep_ks_mult_ctrl_skew #(
    parameter int ROW    = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              s_rst_n,
    input  logic              avail_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              avail_o,
    output logic [DATA_W-1:0] data_o
);
    logic [ROW-1:0]    avail_q;
    logic [DATA_W-1:0] data_q [ROW];

    for (genvar gi = 0; gi < ROW; gi++) begin : g_stage
        logic              avail_in;
        logic [DATA_W-1:0] data_in;

        if (gi == 0) begin : g_head
            assign avail_in = avail_i;
            assign data_in  = data_i;
        end else begin : g_body
            assign avail_in = avail_q[gi-1];
            assign data_in  = data_q[gi-1];
        end

        always_ff @(posedge clk) begin
            if (!s_rst_n) avail_q[gi] <= 1'b0;
            else          avail_q[gi] <= avail_in;
        end

        always_ff @(posedge clk) begin
            data_q[gi] <= data_in;
        end
    end

    assign avail_o = avail_q[ROW-1];
    assign data_o  = data_q[ROW-1];
endmodule

// File: rtl/pep_ks_mult_ctrl.sv
// Buffers coefficient lines, releases credit-gated gap-free level bursts and skews
// them row by row into the key-switch multiplier array.
module pep_ks_mult_ctrl
    import pep_ks_mult_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CREDIT_W   = 4
) (
    input  logic                        clk,
    input  logic                        s_rst_n,
    pep_ks_mult_ctrl_if.slave           in_if,
    input  logic                        ksk_credit_inc,
    output logic [LINE_DATA_W-1:0]      ctrl_mult_data,
    output logic [LINE_SIGN_W-1:0]      ctrl_mult_sign,
    output logic [LBY-1:0]              ctrl_mult_avail,
    output logic                        ctrl_mult_last_eol,
    output logic                        ctrl_mult_last_eoy,
    output logic                        ctrl_mult_last_last_iter,
    output logic [TOTAL_BATCH_NB_W-1:0] ctrl_mult_last_batch_id,
    output logic [PID_W-1:0]            ctrl_mult_last_pid,
    output logic                        error
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LVL_W = (LVL_CYC > 1) ? $clog2(LVL_CYC) : 1;
    localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]    CNT_LVL    = CNT_W'(LVL_CYC);
    localparam logic [LVL_W-1:0]    LVL_LAST   = LVL_W'(LVL_CYC - 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

    ks_line_t            fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    ks_state_e           state_q, state_d;
    logic [LVL_W-1:0]    lvl_cnt_q, lvl_cnt_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                error_q, error_d;
    logic                issue_avail_q;
    ks_line_t            issue_line_q;

    ks_line_t push_line, pop_line;
    logic     push, pop, start, burst_end, lvl_err, credit_err;
    logic     start_idle, start_next, rdy;

    always_comb begin
        push_line.data           = in_if.in_data;
        push_line.sign           = in_if.in_sign;
        push_line.info.eol       = in_if.in_eol;
        push_line.info.eoy       = in_if.in_eoy;
        push_line.info.last_iter = in_if.in_last_iter;
        push_line.info.batch_id  = in_if.in_batch_id;
        push_line.info.pid       = in_if.in_pid;
    end

    assign rdy          = (count_q != CNT_FULL);
    assign in_if.in_rdy = rdy;
    assign push         = in_if.in_vld & rdy;
    assign pop_line     = fifo_mem_q[rd_ptr_q];

    // Chaining straight from a finishing burst must leave a full group behind the line being popped.
    assign start_idle = (count_q >= CNT_LVL) && (credit_q != '0);
    assign start_next = (count_q > CNT_LVL) && (credit_q != '0);

    always_comb begin
        state_d   = state_q;
        lvl_cnt_d = lvl_cnt_q;
        pop       = 1'b0;
        start     = 1'b0;
        burst_end = 1'b0;
        lvl_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_idle) begin
                    pop     = 1'b1;
                    start   = 1'b1;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: pop = 1'b1;
            default:  state_d = ST_IDLE;
        endcase
        if (pop) begin
            burst_end = pop_line.info.eol | (lvl_cnt_q == LVL_LAST);
            lvl_err   = pop_line.info.eol ^ (lvl_cnt_q == LVL_LAST);
            if (burst_end) begin
                lvl_cnt_d = '0;
                if (state_q == ST_BURST && start_next) begin
                    start   = 1'b1;
                    state_d = ST_BURST;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                lvl_cnt_d = lvl_cnt_q + LVL_W'(1);
            end
        end
    end

    always_comb begin
        credit_d   = credit_q;
        credit_err = 1'b0;
        if (ksk_credit_inc && !start) begin
            if (credit_q == CREDIT_MAX) credit_err = 1'b1;
            else                        credit_d   = credit_q + CREDIT_W'(1);
        end else if (!ksk_credit_inc && start) begin
            credit_d = credit_q - CREDIT_W'(1);
        end
    end

    assign wr_ptr_d = !push ? wr_ptr_q : (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    assign rd_ptr_d = !pop  ? rd_ptr_q : (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    assign count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    assign error_d  = lvl_err | credit_err;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= ST_IDLE;
            lvl_cnt_q     <= '0;
            credit_q      <= '0;
            error_q       <= 1'b0;
            issue_avail_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            lvl_cnt_q     <= lvl_cnt_d;
            credit_q      <= credit_d;
            error_q       <= error_d;
            issue_avail_q <= pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= push_line;
        if (pop)  issue_line_q         <= pop_line;
    end

    assign error = error_q;

    // Row y sees the issue register y cycles late, so each row stays contiguous per coefficient.
    for (genvar gi = 0; gi < LBY; gi++) begin : g_row
        if (gi == 0) begin : g_direct
            assign ctrl_mult_avail[0]              = issue_avail_q;
            assign ctrl_mult_data[0 +: ROW_DATA_W] = issue_line_q.data[0 +: ROW_DATA_W];
            assign ctrl_mult_sign[0 +: LBZ]        = issue_line_q.sign[0 +: LBZ];
        end else begin : g_skew
            logic [ROW_DATA_W+LBZ-1:0] row_out;
            pep_ks_mult_ctrl_skew #(.ROW(gi), .DATA_W(ROW_DATA_W + LBZ)) u_skew (
                .clk     (clk),
                .s_rst_n (s_rst_n),
                .avail_i (issue_avail_q),
                .data_i  ({issue_line_q.data[gi*ROW_DATA_W +: ROW_DATA_W],
                           issue_line_q.sign[gi*LBZ +: LBZ]}),
                .avail_o (ctrl_mult_avail[gi]),
                .data_o  (row_out)
            );
            assign ctrl_mult_data[gi*ROW_DATA_W +: ROW_DATA_W] = row_out[LBZ +: ROW_DATA_W];
            assign ctrl_mult_sign[gi*LBZ +: LBZ]               = row_out[0 +: LBZ];
        end
    end

    logic          info_avail;
    ks_ctrl_info_t info_dly;

    if (LBY > 1) begin : g_info_skew
        pep_ks_mult_ctrl_skew #(.ROW(LBY - 1), .DATA_W($bits(ks_ctrl_info_t))) u_info (
            .clk     (clk),
            .s_rst_n (s_rst_n),
            .avail_i (issue_avail_q),
            .data_i  (issue_line_q.info),
            .avail_o (info_avail),
            .data_o  (info_dly)
        );
    end else begin : g_info_direct
        assign info_avail = issue_avail_q;
        assign info_dly   = issue_line_q.info;
    end

    assign ctrl_mult_last_eol       = info_avail & info_dly.eol;
    assign ctrl_mult_last_eoy       = info_avail & info_dly.eoy;
    assign ctrl_mult_last_last_iter = info_avail & info_dly.last_iter;
    assign ctrl_mult_last_batch_id  = info_avail ? info_dly.batch_id : '0;
    assign ctrl_mult_last_pid       = info_avail ? info_dly.pid : '0;
endmodule
